// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline write-back has priority, long-unit results queue in a FIFO.
// Optional statistics counters are enabled with the WB_ARB_STATS_EN macro.
module wb_port_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        PipeRegWriteIn,
  input  logic [4:0]  PipeDestIn,
  input  logic [31:0] PipeDataIn,
  input  logic        LongValidIn,
  input  logic [4:0]  LongDestIn,
  input  logic [31:0] LongDataIn,
  output logic        LongReadyOut,
  output logic        RegWriteOut,
  output logic [4:0]  DestinationRegOut,
  output logic [31:0] RegWriteDataOut,
  output logic        PipeStallOut,
  input  logic [4:0]  QueryRegIn,
  output logic        QueryHitOut,
  output logic        PendingOut,
  output logic [15:0] LongWriteCountOut,
  output logic [15:0] StallCountOut
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int AGE_W = $clog2(STARVE_LIMIT + 1);

  logic [4:0]       r_dest [DEPTH];
  logic [31:0]      r_data [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [AGE_W-1:0] r_age;

  logic        w_pipe_busy;
  logic        w_empty;
  logic        w_accept_nz;
  logic        w_stall;
  logic        w_pop;
  logic        w_bypass;
  logic        w_push;
  logic        w_grant;
  logic [4:0]  w_gnt_dest;
  logic [31:0] w_gnt_data;
  logic        w_hit;

  assign w_pipe_busy  = PipeRegWriteIn && (PipeDestIn != 5'd0);
  assign w_empty      = (r_count == '0);
  assign LongReadyOut = (r_count < CNT_W'(DEPTH));
  assign w_accept_nz  = LongValidIn && LongReadyOut && (LongDestIn != 5'd0);
  assign w_stall      = (r_age == AGE_W'(STARVE_LIMIT)) && !w_empty;
  // Head pops when starving the pipe, or whenever the pipe leaves the port free.
  assign w_pop        = !w_empty && (w_stall || !w_pipe_busy);
  assign w_bypass     = w_empty && !w_pipe_busy && w_accept_nz;
  assign w_push       = w_accept_nz && !w_bypass;

  assign PipeStallOut = w_stall;
  assign PendingOut   = !w_empty;

  always_comb begin
    w_grant    = 1'b0;
    w_gnt_dest = '0;
    w_gnt_data = '0;
    if (w_pop) begin
      w_grant    = 1'b1;
      w_gnt_dest = r_dest[r_rd_ptr];
      w_gnt_data = r_data[r_rd_ptr];
    end else if (w_pipe_busy) begin
      w_grant    = 1'b1;
      w_gnt_dest = PipeDestIn;
      w_gnt_data = PipeDataIn;
    end else if (w_bypass) begin
      w_grant    = 1'b1;
      w_gnt_dest = LongDestIn;
      w_gnt_data = LongDataIn;
    end
  end

  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[i] && (r_dest[i] == QueryRegIn)) w_hit = 1'b1;
    end
  end
  assign QueryHitOut = w_hit && (QueryRegIn != 5'd0);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_dest[i] <= '0;
        r_data[i] <= '0;
      end
      r_vld    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_pop) begin
        r_vld[r_rd_ptr] <= 1'b0;
        r_rd_ptr        <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push) begin
        r_dest[r_wr_ptr] <= LongDestIn;
        r_data[r_wr_ptr] <= LongDataIn;
        r_vld[r_wr_ptr]  <= 1'b1;
        r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_age <= '0;
    end else if (w_empty || w_pop) begin
      r_age <= '0;
    end else if (r_age != AGE_W'(STARVE_LIMIT)) begin
      r_age <= r_age + AGE_W'(1);
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      RegWriteOut       <= 1'b0;
      DestinationRegOut <= '0;
      RegWriteDataOut   <= '0;
    end else begin
      RegWriteOut <= w_grant;
      if (w_grant) begin
        DestinationRegOut <= w_gnt_dest;
        RegWriteDataOut   <= w_gnt_data;
      end
    end
  end

`ifdef WB_ARB_STATS_EN
  logic [15:0] r_long_cnt;
  logic [15:0] r_stall_cnt;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_long_cnt  <= '0;
      r_stall_cnt <= '0;
    end else begin
      if ((w_pop || w_bypass) && (r_long_cnt != 16'hFFFF)) r_long_cnt <= r_long_cnt + 16'd1;
      if (w_stall && (r_stall_cnt != 16'hFFFF)) r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign LongWriteCountOut = r_long_cnt;
  assign StallCountOut     = r_stall_cnt;
`else
  assign LongWriteCountOut = '0;
  assign StallCountOut     = '0;
`endif

endmodule
